nrx_mainctl: RTL and testbench
==============================

# nrx_mainctl

Parametrised main-CPU control block for the Namco/Rally-X family boards: a bank of memory-mapped 1-bit latches, a multi-source interrupt controller with per-source enable, IRQ/NMI routing and optional vectored priority, plus an optional watchdog. Sits on the main Z80 bus in the CPU clock domain, between the external address decoder and the T80 core's INT_n/NMI_n inputs. It generalises the single-source vblank interrupt and fixed latch set of the current main board.

## Interface
- NLATCH, 6: number of output latch bits, 1..8, at offsets 0..NLATCH-1
- NSRC, 2: number of interrupt sources, 1..4, enable registers at offsets 8..8+NSRC-1
- NMI_MASK, 0: NSRC-bit mask; a set bit routes that source to NMI_n instead of INT_n
- VMODE, 0: 0 = VEC is the raw latched byte; 1 = VEC[2:1] replaced by the acknowledged source index
- WDT_BITS, 16: watchdog counter width, 4..24
- CLK  in  1  CPU clock; all state updates on rising edge
- RESET_n  in  1  asynchronous, active-low reset
- AD  in  4  offset within the decoded control window
- DI  in  8  CPU write data
- LWE  in  1  control-window write strobe, decoded externally
- IOWE  in  1  I/O write cycle; loads vector base from DI
- IACK  in  1  interrupt-acknowledge cycle (M1 and IORQ active), level
- SRC  in  NSRC  level interrupt sources, active high
- LATCH  out  NLATCH  latch bits
- VEC  out  8  vector byte driven onto the data bus during IACK
- INT_n  out  1  maskable interrupt request, active low
- NMI_n  out  1  non-maskable interrupt request, active low
- WDT_RST  out  1  one-cycle watchdog-expiry pulse

## Operation
- Reset: LATCH=0, vector base=0, VEC=0, enables=0, pending=0, INT_n=1, NMI_n=1, WDT_RST=0, watchdog count=0, SRC history=all ones (no spurious edge on release).
- Latches: LWE with AD=k<NLATCH sets LATCH[k]<=DI[0]. Offsets NLATCH..7 and 12..14 ignored.
- Enables: LWE with AD=8+s (s<NSRC) sets en[s]<=DI[0] and clears pending[s] regardless of the value written.
- Edge detect: pending[s] set when en[s]=1 and SRC[s] is sampled 1 while its previous sample was 0. A simultaneous enable write to the same source wins, leaving pending cleared.
- INT_n = ~OR(pending & ~NMI_MASK); NMI_n = ~OR(pending & NMI_MASK). NMI pending clears only by enable write.
- Priority: lowest-index pending INT source wins.
- Acknowledge: on the first IACK cycle (IACK=1, previous sample 0), the winning index is captured in ack_idx. VEC reflects ack_idx while IACK stays high. On IACK falling, pending[ack_idx] clears. IACK with no INT pending clears nothing.
- VEC: VMODE=0 → base. VMODE=1 → {base[7:3], ack_idx[1:0], base[0]}.
- IOWE loads base<=DI. It never alters pending.

## Timing
- All register writes take effect at the sampling edge. Outputs change after that edge (1-cycle latency from strobe).
- SRC rising edge sampled at edge N causes INT_n/NMI_n to go low after edge N.
- INT_n/NMI_n are derived from registers only: glitch-free, no combinational path from inputs.
- Back-to-back sources: after the IACK falling clear, the next pending source asserts INT_n in the same cycle.
- An asynchronous reset mid-IACK aborts the acknowledge. Nothing stays pending.

## Configuration
- NRX_MAINCTL_WATCHDOG_EN defined: WDT_BITS counter increments every CLK. LWE at AD=15 clears it. On reaching all-ones, the next edge wraps it to 0 and pulses WDT_RST high for one cycle. A kick on the terminal cycle clears the count and suppresses the pulse.
- Undefined: no counter is built, WDT_RST is tied 0, and AD=15 writes are ignored.

## Structure
- Package nrx_mainctl_pkg holds the offset constants (OFS_IE_BASE=8, OFS_WDT=15), the VMODE encodings, and parameter-range checks.
- Sub-module nrx_irq_prio holds the pending/enable registers, edge detect, priority encoder, ack_idx capture and clear. The top level holds the latches, the vector base and the watchdog.

## Test plan
- Reset release with SRC=2'b11 held high → pending stays 0, INT_n=1. A later SRC[0] 0→1 with en[0]=0 → INT_n stays 1.
- Write en[0]=1, pulse SRC[0] → INT_n low one cycle after the sampling edge. Write en[0]=1 again → INT_n high the next cycle.
- VMODE=1, base=8'hF0, SRC[1] and SRC[0] pending, IACK high 3 cycles → VEC=8'hF0, pending[0] cleared on IACK fall. Second IACK → VEC=8'hF2, INT_n high afterwards.
- NMI_MASK=2'b10, SRC[1] edge → NMI_n low, INT_n high. IACK does not clear it. Writing AD=9 releases NMI_n.
- LWE AD=0..5 with DI=8'h01, then AD=3 with DI=8'h00 → LATCH=6'b110111. AD=6 write → no change.
- WATCHDOG_EN, WDT_BITS=4 → WDT_RST pulses at cycle 16 after reset, every 16 cycles thereafter. A kick at cycle 15 suppresses the pulse.

Source files
------------

// File: rtl/nrx_mainctl_pkg.sv
// Shared constants and helpers for the Rally-X main-CPU control block:
// register offsets, vector modes, parameter sanity and vector formatting.
package nrx_mainctl_pkg;

    localparam logic [3:0] OFS_IE_BASE = 4'd8;
    localparam logic [3:0] OFS_WDT     = 4'd15;

    localparam int VMODE_RAW = 0;
    localparam int VMODE_IDX = 1;

    function automatic bit params_ok(int nlatch, int nsrc, int vmode, int wdt_bits);
        return (nlatch >= 1) && (nlatch <= 8) &&
               (nsrc >= 1) && (nsrc <= 4) &&
               ((vmode == VMODE_RAW) || (vmode == VMODE_IDX)) &&
               (wdt_bits >= 4) && (wdt_bits <= 24);
    endfunction

    // Indexed mode folds the acknowledged source into bits 2:1, IM2 style.
    function automatic logic [7:0] vec_byte(int vmode, logic [7:0] base, logic [1:0] idx);
        return (vmode == VMODE_IDX) ? {base[7:3], idx, base[0]} : base;
    endfunction

endpackage

// File: rtl/nrx_mainctl_if.sv
// Main Z80 bus view of the control window: decoded strobes in, vector byte out.
interface nrx_mainctl_if;

    logic [3:0] AD;
    logic [7:0] DI;
    logic       LWE;
    logic       IOWE;
    logic       IACK;
    logic [7:0] VEC;

    modport master (output AD, DI, LWE, IOWE, IACK, input VEC);
    modport slave  (input AD, DI, LWE, IOWE, IACK, output VEC);

endinterface

// File: rtl/nrx_irq_prio.sv
// Interrupt core: per-source enable, rising-edge pending, IRQ/NMI routing,
// lowest-index priority and acknowledge capture/clear.
module nrx_irq_prio
    import nrx_mainctl_pkg::*;
#(
    parameter int              NSRC     = 2,
    parameter logic [NSRC-1:0] NMI_MASK = '0
) (
    input  logic            CLK,
    input  logic            RESET_n,
    input  logic [NSRC-1:0] ie_wr,
    input  logic            ie_val,
    input  logic            IACK,
    input  logic [NSRC-1:0] SRC,
    output logic [1:0]      ack_idx,
    output logic            INT_n,
    output logic            NMI_n
);

    logic [NSRC-1:0] en;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] src_prev;
    logic [NSRC-1:0] int_pend;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] pending_nxt;
    logic            iack_prev;
    logic            ack_vld;
    logic [1:0]      win_idx;
    logic            win_vld;

    assign int_pend = pending & ~NMI_MASK;

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int s = NSRC - 1; s >= 0; s--) begin
            if (int_pend[s]) begin
                win_idx = 2'(s);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (!IACK && iack_prev && ack_vld && (ack_idx == 2'(s)))
                ack_clr[s] = 1'b1;
        end
    end

    // An enable write beats a coincident edge on the same source.
    assign pending_nxt = ((pending & ~ack_clr) | (SRC & ~src_prev & en)) & ~ie_wr;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            en        <= '0;
            pending   <= '0;
            src_prev  <= '1;
            iack_prev <= 1'b0;
            ack_vld   <= 1'b0;
            ack_idx   <= '0;
        end else begin
            src_prev  <= SRC;
            iack_prev <= IACK;
            pending   <= pending_nxt;
            for (int s = 0; s < NSRC; s++) begin
                if (ie_wr[s])
                    en[s] <= ie_val;
            end
            if (IACK && !iack_prev) begin
                ack_idx <= win_idx;
                ack_vld <= win_vld;
            end else if (!IACK && iack_prev) begin
                ack_vld <= 1'b0;
            end
        end
    end

    assign INT_n = ~|int_pend;
    assign NMI_n = ~|(pending & NMI_MASK);

endmodule

// File: rtl/nrx_mainctl.sv
// Rally-X main-CPU control block: latch bank, vector base, interrupt core and
// optional watchdog (built when NRX_MAINCTL_WATCHDOG_EN is defined).
module nrx_mainctl
    import nrx_mainctl_pkg::*;
#(
    parameter int              NLATCH   = 6,
    parameter int              NSRC     = 2,
    parameter logic [NSRC-1:0] NMI_MASK = '0,
    parameter int              VMODE    = 0,
    parameter int              WDT_BITS = 16
) (
    input  logic              CLK,
    input  logic              RESET_n,
    nrx_mainctl_if.slave      bus,
    input  logic [NSRC-1:0]   SRC,
    output logic [NLATCH-1:0] LATCH,
    output logic              INT_n,
    output logic              NMI_n,
    output logic              WDT_RST
);

    if (!params_ok(NLATCH, NSRC, VMODE, WDT_BITS)) begin : g_bad_params
        $error("nrx_mainctl: parameter out of range");
    end

    logic [7:0]      base;
    logic [1:0]      ack_idx;
    logic [NSRC-1:0] ie_wr;

    always_comb begin
        ie_wr = '0;
        for (int s = 0; s < NSRC; s++)
            ie_wr[s] = bus.LWE && (bus.AD == OFS_IE_BASE + 4'(s));
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            LATCH <= '0;
            base  <= '0;
        end else begin
            for (int k = 0; k < NLATCH; k++) begin
                if (bus.LWE && (bus.AD == 4'(k)))
                    LATCH[k] <= bus.DI[0];
            end
            if (bus.IOWE)
                base <= bus.DI;
        end
    end

    nrx_irq_prio #(
        .NSRC     (NSRC),
        .NMI_MASK (NMI_MASK)
    ) u_irq (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .ie_wr   (ie_wr),
        .ie_val  (bus.DI[0]),
        .IACK    (bus.IACK),
        .SRC     (SRC),
        .ack_idx (ack_idx),
        .INT_n   (INT_n),
        .NMI_n   (NMI_n)
    );

    assign bus.VEC = vec_byte(VMODE, base, ack_idx);

`ifdef NRX_MAINCTL_WATCHDOG_EN
    logic [WDT_BITS-1:0] wdt_cnt;
    logic                kick;

    assign kick = bus.LWE && (bus.AD == OFS_WDT);

    // A kick on the terminal count wins over the expiry pulse.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wdt_cnt <= '0;
            WDT_RST <= 1'b0;
        end else if (kick) begin
            wdt_cnt <= '0;
            WDT_RST <= 1'b0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
            WDT_RST <= &wdt_cnt;
        end
    end
`else
    assign WDT_RST = 1'b0;
`endif

endmodule

// File: tb/tb_nrx_mainctl.sv
// Scoreboard bench for nrx_mainctl: a cycle-level reference model queues the
// expected outputs for every clock edge and a monitor compares them.
module tb_nrx_mainctl;

    localparam int              NLATCH   = 6;
    localparam int              NSRC     = 3;
    localparam logic [NSRC-1:0] NMI_MASK = 3'b100;
    localparam int              VMODE    = 1;
    localparam int              WDT_BITS = 4;

    logic              CLK = 1'b0;
    logic              RESET_n = 1'b0;
    logic [NSRC-1:0]   SRC;
    logic [NLATCH-1:0] LATCH;
    logic              INT_n;
    logic              NMI_n;
    logic              WDT_RST;

    nrx_mainctl_if bus ();

    nrx_mainctl #(
        .NLATCH   (NLATCH),
        .NSRC     (NSRC),
        .NMI_MASK (NMI_MASK),
        .VMODE    (VMODE),
        .WDT_BITS (WDT_BITS)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .bus     (bus.slave),
        .SRC     (SRC),
        .LATCH   (LATCH),
        .INT_n   (INT_n),
        .NMI_n   (NMI_n),
        .WDT_RST (WDT_RST)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NLATCH-1:0] latch;
        logic [7:0]        vec;
        logic              int_n;
        logic              nmi_n;
        logic              wdt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state, as the programmer sees the block.
    logic [NLATCH-1:0] mlatch;
    logic [7:0]        mbase;
    logic [NSRC-1:0]   men;
    logic [NSRC-1:0]   mpend;
    logic [NSRC-1:0]   msrc_prev;
    logic              miack_prev;
    int                mack;
    logic              mack_vld;
    int                mwdt;
    logic              mwdt_p;

    logic [NSRC-1:0]   rsrc;
    logic              riack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mlatch     = '0;
        mbase      = '0;
        men        = '0;
        mpend      = '0;
        msrc_prev  = '1;
        miack_prev = 1'b0;
        mack       = 0;
        mack_vld   = 1'b0;
        mwdt       = 0;
        mwdt_p     = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] ad, input logic [7:0] di, input logic lwe,
                              input logic iowe, input logic iack, input logic [NSRC-1:0] src);
        int              win;
        logic [NSRC-1:0] npend;
        exp_t            e;
        win = -1;
        for (int s = 0; s < NSRC; s++)
            if (win < 0 && mpend[s] && !NMI_MASK[s]) win = s;
        npend = mpend;
        if (!iack && miack_prev && mack_vld) npend[mack] = 1'b0;
        for (int s = 0; s < NSRC; s++)
            if (men[s] && src[s] && !msrc_prev[s]) npend[s] = 1'b1;
        for (int s = 0; s < NSRC; s++)
            if (lwe && int'(ad) == 8 + s) begin
                npend[s] = 1'b0;
                men[s]   = di[0];
            end
        if (iack && !miack_prev) begin
            mack     = (win < 0) ? 0 : win;
            mack_vld = (win >= 0);
        end else if (!iack && miack_prev) begin
            mack_vld = 1'b0;
        end
        mpend      = npend;
        msrc_prev  = src;
        miack_prev = iack;
        if (lwe && int'(ad) < NLATCH) mlatch[ad] = di[0];
        if (iowe) mbase = di;
`ifdef NRX_MAINCTL_WATCHDOG_EN
        if (lwe && ad == 4'd15) begin
            mwdt   = 0;
            mwdt_p = 1'b0;
        end else if (mwdt == (1 << WDT_BITS) - 1) begin
            mwdt   = 0;
            mwdt_p = 1'b1;
        end else begin
            mwdt   = mwdt + 1;
            mwdt_p = 1'b0;
        end
`else
        mwdt_p = 1'b0;
`endif
        e.latch = mlatch;
        e.vec   = (VMODE == 1) ? ((mbase & 8'hF9) | 8'(mack << 1)) : mbase;
        e.int_n = ((mpend & ~NMI_MASK) == '0);
        e.nmi_n = ((mpend & NMI_MASK) == '0);
        e.wdt   = mwdt_p;
        sb.push_back(e);
    endtask

    // One bus cycle: inputs change mid-cycle, sampled at the next rising edge.
    task automatic cyc(input logic [3:0] ad, input logic [7:0] di, input logic lwe,
                       input logic iowe, input logic iack, input logic [NSRC-1:0] src);
        @(negedge CLK);
        bus.AD   = ad;
        bus.DI   = di;
        bus.LWE  = lwe;
        bus.IOWE = iowe;
        bus.IACK = iack;
        SRC      = src;
        model_step(ad, di, lwe, iowe, iack, src);
    endtask

    task automatic idle(input int n, input logic iack, input logic [NSRC-1:0] src);
        for (int i = 0; i < n; i++) cyc(4'd0, 8'd0, 1'b0, 1'b0, iack, src);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset(input logic iack_hold, input logic [NSRC-1:0] src);
        @(negedge CLK);
        bus.LWE  = 1'b0;
        bus.IOWE = 1'b0;
        bus.IACK = iack_hold;
        SRC      = src;
        #2 RESET_n = 1'b0;
        model_reset();
        #1;
        chk("rst_latch", 32'(LATCH), 32'd0);
        chk("rst_vec",   32'(bus.VEC), 32'd0);
        chk("rst_int_n", 32'(INT_n), 32'd1);
        chk("rst_nmi_n", 32'(NMI_n), 32'd1);
        chk("rst_wdt",   32'(WDT_RST), 32'd0);
        @(negedge CLK);
        bus.IACK = 1'b0;
        @(posedge CLK);
        #2 RESET_n = 1'b1;
    endtask

    // Monitor: every edge that the driver scheduled has one expected record.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_latch", 32'(LATCH),   32'(e.latch));
                chk("sb_vec",   32'(bus.VEC), 32'(e.vec));
                chk("sb_int_n", 32'(INT_n),   32'(e.int_n));
                chk("sb_nmi_n", 32'(NMI_n),   32'(e.nmi_n));
                chk("sb_wdt",   32'(WDT_RST), 32'(e.wdt));
            end
        end
    end

    initial begin
        bus.AD = '0; bus.DI = '0; bus.LWE = 1'b0; bus.IOWE = 1'b0; bus.IACK = 1'b0;
        SRC = '1;
        model_reset();

        // Sources held high through reset release, then an edge while disabled.
        do_reset(1'b0, 3'b111);
        idle(3, 1'b0, 3'b111);
        settle();
        chk("no_spurious_edge", 32'(INT_n), 32'd1);
        idle(1, 1'b0, 3'b110);
        idle(1, 1'b0, 3'b111);
        settle();
        chk("disabled_edge", 32'(INT_n), 32'd1);

        // Enable, edge, then re-writing the enable drops the request.
        cyc(4'd8, 8'h01, 1'b1, 1'b0, 1'b0, 3'b111);
        idle(1, 1'b0, 3'b110);
        idle(1, 1'b0, 3'b111);
        settle();
        chk("edge_int_low", 32'(INT_n), 32'd0);
        cyc(4'd8, 8'h01, 1'b1, 1'b0, 1'b0, 3'b111);
        settle();
        chk("ie_write_clears", 32'(INT_n), 32'd1);

        // Two pending sources acknowledged in priority order with indexed vectors.
        cyc(4'd0, 8'hF0, 1'b0, 1'b1, 1'b0, 3'b111);
        cyc(4'd9, 8'h01, 1'b1, 1'b0, 1'b0, 3'b111);
        idle(1, 1'b0, 3'b000);
        idle(1, 1'b0, 3'b011);
        idle(3, 1'b1, 3'b011);
        settle();
        chk("vec_first_ack", 32'(bus.VEC), 32'hF0);
        idle(1, 1'b0, 3'b011);
        settle();
        chk("int_after_first_ack", 32'(INT_n), 32'd0);
        idle(2, 1'b1, 3'b011);
        settle();
        chk("vec_second_ack", 32'(bus.VEC), 32'hF2);
        idle(1, 1'b0, 3'b011);
        settle();
        chk("int_after_second_ack", 32'(INT_n), 32'd1);

        // NMI-routed source: ignores IACK, released only by its enable write.
        cyc(4'd10, 8'h01, 1'b1, 1'b0, 1'b0, 3'b011);
        idle(1, 1'b0, 3'b111);
        settle();
        chk("nmi_low", 32'(NMI_n), 32'd0);
        chk("nmi_not_int", 32'(INT_n), 32'd1);
        idle(2, 1'b1, 3'b111);
        idle(1, 1'b0, 3'b111);
        settle();
        chk("nmi_survives_iack", 32'(NMI_n), 32'd0);
        cyc(4'd10, 8'h00, 1'b1, 1'b0, 1'b0, 3'b111);
        settle();
        chk("nmi_released", 32'(NMI_n), 32'd1);

        // Latch bank, including ignored offsets.
        for (int k = 0; k < NLATCH; k++) cyc(4'(k), 8'h01, 1'b1, 1'b0, 1'b0, 3'b111);
        cyc(4'd3, 8'h00, 1'b1, 1'b0, 1'b0, 3'b111);
        settle();
        chk("latch_pattern", 32'(LATCH), 32'b110111);
        cyc(4'd6, 8'h01, 1'b1, 1'b0, 1'b0, 3'b111);
        cyc(4'd12, 8'h01, 1'b1, 1'b0, 1'b0, 3'b111);
        settle();
        chk("latch_ignored_ofs", 32'(LATCH), 32'b110111);

        // Reset arriving in the middle of an acknowledge.
        cyc(4'd8, 8'h01, 1'b1, 1'b0, 1'b0, 3'b110);
        idle(1, 1'b0, 3'b111);
        idle(2, 1'b1, 3'b111);
        do_reset(1'b1, 3'b111);
        idle(2, 1'b0, 3'b111);
        settle();
        chk("post_abort_int_n", 32'(INT_n), 32'd1);

        // Randomised traffic against the model.
        rsrc  = '1;
        riack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rsrc = NSRC'($urandom);
            if ($urandom_range(4) == 0) riack = ~riack;
            cyc(4'($urandom_range(15)), 8'($urandom), ($urandom_range(2) == 0),
                ($urandom_range(7) == 0), riack, rsrc);
        end

`ifdef NRX_MAINCTL_WATCHDOG_EN
        // Free-running expiry after reset, then a kick on the terminal cycle.
        do_reset(1'b0, 3'b111);
        idle(15, 1'b0, 3'b111);
        settle();
        chk("wdt_before_expiry", 32'(WDT_RST), 32'd0);
        idle(1, 1'b0, 3'b111);
        settle();
        chk("wdt_expiry_pulse", 32'(WDT_RST), 32'd1);
        do_reset(1'b0, 3'b111);
        idle(15, 1'b0, 3'b111);
        cyc(4'd15, 8'h00, 1'b1, 1'b0, 1'b0, 3'b111);
        settle();
        chk("wdt_kick_suppress", 32'(WDT_RST), 32'd0);
        idle(20, 1'b0, 3'b111);
`endif

        @(posedge CLK);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
